// File: rtl/joy_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : joy_serial_pkg
// Purpose  : Shared types and constants for the multi-player serial joystick
//            deserializer (FSM state encoding, player limit, frame helper).
// Revision : 1.0 - initial release
// ============================================================================
package joy_serial_pkg;

    // Largest chain length the deserializer is qualified for
    localparam int JOY_MAX_PLAYERS = 4;

    // Frame sequencer states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_DONE     = 3'd4
    } joy_state_t;

    // Nominal frame length in ticks: one load tick, a low and a high tick per
    // stream bit, then the idle gap
    function automatic int joy_frame_ticks(input int players, input int bits,
                                           input int idle_ticks);
        return 1 + 2 * players * bits + idle_ticks;
    endfunction

endpackage
`default_nettype wire

// File: rtl/joy_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : joy_tick_gen
// Purpose  : Free-running divider producing a single-cycle tick once every
//            CLK_DIV clk cycles; the tick is high while the counter sits at
//            CLK_DIV-1, so the consuming logic acts on the edge that wraps it.
// Revision : 1.0 - initial release
// ============================================================================
module joy_tick_gen #(
    parameter int CLK_DIV = 32
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int            CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // Divider counter: wraps to zero after reaching CLK_DIV-1
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (div_cnt == CNT_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/joy_serial_mp.sv
`default_nettype none
// ============================================================================
// Module   : joy_serial_mp
// Purpose  : Multi-player serial joystick deserializer. Drives latch/clock of
//            a daisy-chained 74HC165-style shifter, shifts in PLAYERS*BITS
//            active-low button bits per frame and presents them as
//            active-high per-player words with a one-cycle frame_valid.
//            Optional build macro JOY_SERIAL_DEBOUNCE_EN enables per-player
//            frame-to-frame debouncing of joy_out.
// Revision : 1.0 - initial release
// ============================================================================
module joy_serial_mp
    import joy_serial_pkg::*;
#(
    parameter int PLAYERS    = 2,
    parameter int BITS       = 16,
    parameter int CLK_DIV    = 32,
    parameter int IDLE_TICKS = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    joy_data,
    output logic                    joy_clk,
    output logic                    joy_load,
    output logic [PLAYERS*BITS-1:0] joy_out,
    output logic                    frame_valid
);

    localparam int TOTAL = PLAYERS * BITS;
    localparam int K_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int I_W   = $clog2(IDLE_TICKS + 1);

    localparam logic [K_W-1:0] K_LAST    = K_W'(TOTAL - 1);
    localparam logic [I_W-1:0] IDLE_LAST = I_W'(IDLE_TICKS);
    // The tick in which DONE commits is counted as the first idle tick, so a
    // steady-state frame is exactly (1 + 2*TOTAL + IDLE_TICKS) ticks long.
    // Out of reset the count starts at zero, giving the chain one extra tick.
    localparam logic [I_W-1:0] IDLE_RESTART = I_W'(1);

    logic             tick;
    joy_state_t       state;
    joy_state_t       state_nxt;
    logic [K_W-1:0]   k;
    logic [K_W-1:0]   k_nxt;
    logic [I_W-1:0]   idle_cnt;
    logic [I_W-1:0]   idle_nxt;
    logic             clk_nxt;
    logic             load_nxt;
    logic             sample;
    logic             commit;
    logic             sync_meta;
    logic             sync_data;
    logic [TOTAL-1:0] capture;

    joy_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Two-flop synchroniser on the asynchronous chain data line
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_meta <= 1'b1;
            sync_data <= 1'b1;
        end else begin
            sync_meta <= joy_data;
            sync_data <= sync_meta;
        end
    end

    // Next-state, counters and line levels; lines follow the next state so
    // they are registered and only move on tick boundaries
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        idle_nxt  = idle_cnt;
        sample    = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    if (idle_cnt == IDLE_LAST) begin
                        idle_nxt = IDLE_RESTART;
                        if (enable) begin
                            state_nxt = ST_LOAD;
                        end
                    end else begin
                        idle_nxt = idle_cnt + 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (tick) begin
                    k_nxt     = '0;
                    state_nxt = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (tick) begin
                    sample    = 1'b1;
                    state_nxt = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (tick) begin
                    if (k == K_LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        k_nxt     = k + 1'b1;
                        state_nxt = ST_SHIFT_LO;
                    end
                end
            end
            ST_DONE: begin
                commit    = 1'b1;
                k_nxt     = '0;
                idle_nxt  = IDLE_RESTART;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        clk_nxt  = (state_nxt != ST_SHIFT_LO);
        load_nxt = (state_nxt != ST_LOAD);
    end

    // State, counters and registered chain control lines
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            k        <= '0;
            idle_cnt <= '0;
            joy_clk  <= 1'b1;
            joy_load <= 1'b1;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            idle_cnt <= idle_nxt;
            joy_clk  <= clk_nxt;
            joy_load <= load_nxt;
        end
    end

    // Capture register: stream bit k lands at flat index k, which places it
    // in player k/BITS, bit k%BITS; line is active-low, capture active-high
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            capture <= '0;
        end else if (sample) begin
            capture[k] <= ~sync_data;
        end
    end

`ifdef JOY_SERIAL_DEBOUNCE_EN
    logic [TOTAL-1:0] prev_cap;
    logic [TOTAL-1:0] deb_out;

    // Previous raw capture per player, refreshed every committed frame
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_cap <= '0;
        end else if (commit) begin
            prev_cap <= capture;
        end
    end

    // A player's word only moves when two consecutive captures agree
    always_comb begin
        deb_out = joy_out;
        for (int p = 0; p < PLAYERS; p++) begin
            if (capture[p*BITS +: BITS] == prev_cap[p*BITS +: BITS]) begin
                deb_out[p*BITS +: BITS] = capture[p*BITS +: BITS];
            end
        end
    end
`endif

    // Output words and frame strobe update together on the DONE cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            joy_out     <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= commit;
            if (commit) begin
`ifdef JOY_SERIAL_DEBOUNCE_EN
                joy_out <= deb_out;
`else
                joy_out <= capture;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_joy_serial_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_joy_serial_mp
// Purpose  : Self-checking bench for joy_serial_mp with 74HC165 chain models
//            for a 2x16 and a 3x12 configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_joy_serial_mp;

    localparam int DIV = 4;
    localparam int IDL = 2;
    localparam int A_P = 2;
    localparam int A_B = 16;
    localparam int B_P = 3;
    localparam int B_B = 12;
    localparam int NA  = A_P * A_B;
    localparam int NB  = B_P * B_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          enable;
    logic          joy_data_a, joy_clk_a, joy_load_a, fv_a;
    logic [NA-1:0] out_a;
    logic          joy_data_b, joy_clk_b, joy_load_b, fv_b;
    logic [NB-1:0] out_b;

    logic [NA-1:0] line_a = '1;
    logic [NB-1:0] line_b = '1;
    logic [NA-1:0] sr_a   = '1;
    logic [NB-1:0] sr_b   = '1;
    logic          prev_jclk_a = 1'b1;
    logic          prev_jclk_b = 1'b1;

    logic [NA-1:0] q_a[$];
    logic [NB-1:0] q_b[$];

    int checks = 0;
    int errors = 0;

    joy_serial_mp #(.PLAYERS(A_P), .BITS(A_B), .CLK_DIV(DIV), .IDLE_TICKS(IDL)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .joy_data(joy_data_a),
        .joy_clk(joy_clk_a), .joy_load(joy_load_a), .joy_out(out_a), .frame_valid(fv_a));

    joy_serial_mp #(.PLAYERS(B_P), .BITS(B_B), .CLK_DIV(DIV), .IDLE_TICKS(IDL)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .joy_data(joy_data_b),
        .joy_clk(joy_clk_b), .joy_load(joy_load_b), .joy_out(out_b), .frame_valid(fv_b));

    // Chain models: parallel load while latch low, shift toward output on
    // each rising serial clock; stream bit 0 is presented first
    always @(posedge clk) begin
        prev_jclk_a <= joy_clk_a;
        if (!joy_load_a) sr_a <= line_a;
        else if (joy_clk_a && !prev_jclk_a) sr_a <= {1'b1, sr_a[NA-1:1]};
        prev_jclk_b <= joy_clk_b;
        if (!joy_load_b) sr_b <= line_b;
        else if (joy_clk_b && !prev_jclk_b) sr_b <= {1'b1, sr_b[NB-1:1]};
    end
    assign joy_data_a = sr_a[0];
    assign joy_data_b = sr_b[0];

    task automatic wait_frame_a(input int max_cyc, output bit seen, output int falls,
                                output int load_cyc, output int drift);
        logic [NA-1:0] last_out;
        logic          last_clk;
        seen = 1'b0; falls = 0; load_cyc = 0; drift = 0;
        last_out = out_a; last_clk = joy_clk_a;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (last_clk && !joy_clk_a) falls++;
            if (!joy_load_a) load_cyc++;
            if (fv_a) seen = 1'b1;
            else if (out_a !== last_out) drift++;
            last_clk = joy_clk_a; last_out = out_a;
        end
    endtask

    task automatic wait_frame_b(input int max_cyc, output bit seen, output int falls);
        logic last_clk;
        seen = 1'b0; falls = 0; last_clk = joy_clk_b;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (last_clk && !joy_clk_b) falls++;
            if (fv_b) seen = 1'b1;
            last_clk = joy_clk_b;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; enable = 1'b1; line_a = '1; line_b = '1;
        repeat (4) @(negedge clk);
        checks++; if (joy_clk_a !== 1'b1) begin errors++; $display("FAIL reset_joy_clk: got %b expected 1", joy_clk_a); end
        checks++; if (joy_load_a !== 1'b1) begin errors++; $display("FAIL reset_joy_load: got %b expected 1", joy_load_a); end
        checks++; if (out_a !== '0) begin errors++; $display("FAIL reset_joy_out: got %h expected 0", out_a); end
        checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b expected 0", fv_a); end
        checks++; if (out_b !== '0) begin errors++; $display("FAIL reset_joy_out_b: got %h expected 0", out_b); end
    endtask

    task automatic test_first_frame;
        int first_load, load_len, falls, bad_w, low_run;
        logic last_clk;
        bit seen;
        logic [NA-1:0] exp;
        line_a = 32'h7FFF_FFFE;
        q_a.push_back(32'h8000_0001);
        first_load = -1; load_len = 0; falls = 0; bad_w = 0; low_run = 0;
        last_clk = 1'b1; seen = 1'b0;
        reset_n = 1'b1;
        for (int n = 1; n <= 400 && !seen; n++) begin
            @(negedge clk);
            if (!joy_load_a) begin
                if (first_load < 0) first_load = n;
                load_len++;
            end
            if (!joy_clk_a) low_run++;
            else begin
                if (!last_clk) begin
                    falls++;
                    if (low_run != DIV) bad_w++;
                end
                low_run = 0;
            end
            last_clk = joy_clk_a;
            if (fv_a) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL first_frame_timeout: got no frame_valid expected one within 400 cycles"); end
        checks++; if (first_load != 12) begin errors++; $display("FAIL first_load_start: got cycle %0d expected 12", first_load); end
        checks++; if (load_len != DIV) begin errors++; $display("FAIL first_load_width: got %0d expected %0d", load_len, DIV); end
        checks++; if (falls != NA) begin errors++; $display("FAIL first_clk_pulses: got %0d expected %0d", falls, NA); end
        checks++; if (bad_w != 0) begin errors++; $display("FAIL first_clk_width: got %0d bad pulses expected 0", bad_w); end
        exp = (q_a.size() > 0) ? q_a.pop_front() : 'x;
        checks++; if (out_a !== exp) begin errors++; $display("FAIL first_frame_data: got %h expected %h", out_a, exp); end
        @(negedge clk);
        checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL frame_valid_width: got %b expected 0", fv_a); end
    endtask

    task automatic test_patterns;
        logic [NA-1:0] pats[3];
        logic [NA-1:0] exp;
        bit seen;
        int falls, load_cyc, drift;
        pats[0] = NA'($urandom);
        pats[1] = '1;
        pats[2] = '0;
        for (int i = 0; i < 3; i++) begin
            line_a = pats[i];
            q_a.push_back(~pats[i]);
            wait_frame_a(400, seen, falls, load_cyc, drift);
            exp = (q_a.size() > 0) ? q_a.pop_front() : 'x;
            checks++; if (!seen) begin errors++; $display("FAIL pattern%0d_timeout: got no frame_valid expected one", i); end
            checks++; if (out_a !== exp) begin errors++; $display("FAIL pattern%0d_data: got %h expected %h", i, out_a, exp); end
            checks++; if (falls != NA) begin errors++; $display("FAIL pattern%0d_clk_falls: got %0d expected %0d", i, falls, NA); end
            checks++; if (load_cyc != DIV) begin errors++; $display("FAIL pattern%0d_load_cycles: got %0d expected %0d", i, load_cyc, DIV); end
            checks++; if (drift != 0) begin errors++; $display("FAIL pattern%0d_out_stable: got %0d changes expected 0", i, drift); end
        end
    endtask

    task automatic test_players3;
        logic [NB-1:0] pats[2];
        logic [NB-1:0] exp;
        bit seen;
        int falls;
        pats[0] = {12'h003, 12'h002, 12'h001};
        pats[1] = {12'hC0B, 12'h0A5, 12'h5F0};
        wait_frame_b(700, seen, falls);
        checks++; if (!seen) begin errors++; $display("FAIL p3_sync_timeout: got no frame_valid expected one"); end
        for (int i = 0; i < 2; i++) begin
            line_b = ~pats[i];
            q_b.push_back(pats[i]);
            wait_frame_b(700, seen, falls);
            exp = (q_b.size() > 0) ? q_b.pop_front() : 'x;
            checks++; if (!seen) begin errors++; $display("FAIL p3_frame%0d_timeout: got no frame_valid expected one", i); end
            checks++; if (falls != NB) begin errors++; $display("FAIL p3_frame%0d_clk_falls: got %0d expected %0d", i, falls, NB); end
            for (int p = 0; p < B_P; p++) begin
                checks++;
                if (out_b[p*B_B +: B_B] !== exp[p*B_B +: B_B]) begin
                    errors++;
                    $display("FAIL p3_frame%0d_player%0d: got %h expected %h", i, p, out_b[p*B_B +: B_B], exp[p*B_B +: B_B]);
                end
            end
        end
    endtask

    task automatic test_enable_drop;
        logic [NA-1:0] exp;
        logic [NA-1:0] held;
        logic last_clk;
        bit seen, loaded, dropped;
        int falls, load_cyc, drift, rises, fv_cnt;
        wait_frame_a(400, seen, falls, load_cyc, drift);
        checks++; if (!seen) begin errors++; $display("FAIL endrop_sync_timeout: got no frame_valid expected one"); end
        line_a = 32'h1234_5678;
        q_a.push_back(~32'h1234_5678);
        loaded = 1'b0; dropped = 1'b0; rises = 0; last_clk = joy_clk_a;
        for (int i = 0; i < 400 && !dropped; i++) begin
            @(negedge clk);
            if (!joy_load_a) loaded = 1'b1;
            if (loaded && !last_clk && joy_clk_a) rises++;
            if (rises == 6) begin enable = 1'b0; dropped = 1'b1; end
            last_clk = joy_clk_a;
        end
        checks++; if (!dropped) begin errors++; $display("FAIL endrop_bit5_timeout: got %0d rises expected 6", rises); end
        wait_frame_a(400, seen, falls, load_cyc, drift);
        exp = (q_a.size() > 0) ? q_a.pop_front() : 'x;
        checks++; if (!seen) begin errors++; $display("FAIL endrop_complete: got no frame_valid expected one"); end
        checks++; if (out_a !== exp) begin errors++; $display("FAIL endrop_data: got %h expected %h", out_a, exp); end
        held = exp; load_cyc = 0; fv_cnt = 0; drift = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (!joy_load_a) load_cyc++;
            if (fv_a) fv_cnt++;
            if (out_a !== held) drift++;
        end
        checks++; if (load_cyc != 0) begin errors++; $display("FAIL endrop_no_load: got %0d load cycles expected 0", load_cyc); end
        checks++; if (fv_cnt != 0) begin errors++; $display("FAIL endrop_no_frame: got %0d pulses expected 0", fv_cnt); end
        checks++; if (drift != 0) begin errors++; $display("FAIL endrop_out_held: got %0d changes expected 0", drift); end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic [NA-1:0] exp;
        logic last_clk;
        bit loaded, hit, seen;
        int falls, first_load;
        line_a = 32'hDEAD_BEEF;
        loaded = 1'b0; hit = 1'b0; falls = 0; last_clk = joy_clk_a;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (!joy_load_a) loaded = 1'b1;
            if (loaded && last_clk && !joy_clk_a) falls++;
            if (falls == 11) hit = 1'b1;
            last_clk = joy_clk_a;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstmid_bit10_timeout: got %0d falls expected 11", falls); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (joy_clk_a !== 1'b1) begin errors++; $display("FAIL rstmid_joy_clk: got %b expected 1", joy_clk_a); end
        checks++; if (joy_load_a !== 1'b1) begin errors++; $display("FAIL rstmid_joy_load: got %b expected 1", joy_load_a); end
        checks++; if (out_a !== '0) begin errors++; $display("FAIL rstmid_joy_out: got %h expected 0", out_a); end
        checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL rstmid_frame_valid: got %b expected 0", fv_a); end
        repeat (2) @(negedge clk);
        q_a.push_back(~32'hDEAD_BEEF);
        reset_n = 1'b1;
        first_load = -1; seen = 1'b0;
        for (int n = 1; n <= 400 && !seen; n++) begin
            @(negedge clk);
            if (!joy_load_a && first_load < 0) first_load = n;
            if (fv_a) seen = 1'b1;
        end
        exp = (q_a.size() > 0) ? q_a.pop_front() : 'x;
        checks++; if (first_load != 12) begin errors++; $display("FAIL rstmid_restart_load: got cycle %0d expected 12", first_load); end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_restart_timeout: got no frame_valid expected one"); end
        checks++; if (out_a !== exp) begin errors++; $display("FAIL rstmid_restart_data: got %h expected %h", out_a, exp); end
    endtask

`ifdef JOY_SERIAL_DEBOUNCE_EN
    task automatic test_debounce;
        logic [NA-1:0] v, g, exp;
        logic [NA-1:0] lines[6];
        bit seen;
        int falls, load_cyc, drift;
        v = 32'h0000_0021;
        g = v ^ 32'h0000_0008;
        lines[0] = v; lines[1] = v; lines[2] = g; lines[3] = v; lines[4] = g; lines[5] = g;
        q_a.push_back('0); q_a.push_back(v); q_a.push_back(v);
        q_a.push_back(v);  q_a.push_back(v); q_a.push_back(g);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            line_a = ~lines[i];
            wait_frame_a(400, seen, falls, load_cyc, drift);
            exp = (q_a.size() > 0) ? q_a.pop_front() : 'x;
            checks++; if (!seen) begin errors++; $display("FAIL debounce%0d_timeout: got no frame_valid expected one", i); end
            checks++; if (out_a !== exp) begin errors++; $display("FAIL debounce%0d_data: got %h expected %h", i, out_a, exp); end
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        test_reset();
`ifdef JOY_SERIAL_DEBOUNCE_EN
        test_debounce();
`else
        test_first_frame();
        test_patterns();
        test_players3();
        test_enable_drop();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
